// File: rtl/pot_smoother.sv
// rtl/pot_smoother.sv - per-channel IIR low-pass with hysteresis gate for pot ADC samples
module pot_smoother #(
    parameter int NUM_POTS = 12,
    parameter int SHIFT    = 2,
    parameter int HYST     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [9:0]              value,
    input  logic [3:0]              pot_index,
    input  logic                    value_valid,
    output logic [10*NUM_POTS-1:0]  pot_values,
    output logic                    change_valid,
    output logic [3:0]              change_index,
    output logic [9:0]              change_value,
    output logic                    overrun,
    output logic                    bad_index
);

    localparam int         AW     = 10 + SHIFT;
    localparam logic [4:0] NP5    = 5'(NUM_POTS);
    localparam logic [9:0] HYST10 = 10'(HYST);
    localparam logic [AW:0] RND   = (AW+1)'(1 << (SHIFT - 1));

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FILTER, S_DECIDE} state_t;

    state_t r_state;
    state_t w_next;

    // per-channel state
    logic [AW-1:0]       r_acc [NUM_POTS];
    logic [9:0]          r_rep [NUM_POTS];
    logic [NUM_POTS-1:0] r_primed;

    // working registers for the sample in flight
    logic [9:0]    r_x;
    logic [3:0]    r_idx;
    logic [AW-1:0] r_acc_w;
    logic [9:0]    r_rep_w;
    logic          r_primed_w;
    logic [AW-1:0] r_acc_n;
    logic [9:0]    r_filt;

    logic          w_in_range;
    logic          w_accept;
    logic [AW:0]   w_acc_sum;
    logic [AW:0]   w_rounded;
    logic [AW-1:0] w_acc_n;
    logic [9:0]    w_filt;
    logic [9:0]    w_diff;
    logic          w_upd;

    assign w_in_range = ({1'b0, pot_index} < NP5);
    assign w_accept   = value_valid && (r_state == S_IDLE) && w_in_range;

    // filter arithmetic; one extra bit keeps the rounding add from wrapping
    always_comb begin
        w_acc_sum = (AW+1)'(r_acc_w) - (AW+1)'(r_acc_w >> SHIFT) + (AW+1)'(r_x);
        w_rounded = (w_acc_sum + RND) >> SHIFT;
        if (!r_primed_w) begin
            w_acc_n = AW'(r_x) << SHIFT;
            w_filt  = r_x;
        end else begin
            w_acc_n = w_acc_sum[AW-1:0];
            w_filt  = (w_rounded > (AW+1)'(1023)) ? 10'd1023 : w_rounded[9:0];
        end
    end

    // hysteresis gate with endpoint overrides so the rails are always reachable
    always_comb begin
        w_diff = (r_filt > r_rep_w) ? (r_filt - r_rep_w) : (r_rep_w - r_filt);
        w_upd  = !r_primed_w
              || (w_diff > HYST10)
              || (r_filt == 10'd0    && r_rep_w != 10'd0)
              || (r_filt == 10'd1023 && r_rep_w != 10'd1023);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next-state: fixed four-cycle walk once a sample is accepted
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_LOAD;
            S_LOAD:   w_next = S_FILTER;
            S_FILTER: w_next = S_DECIDE;
            S_DECIDE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // datapath, channel memory, change strobe and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_POTS; i++) begin
                r_acc[i] <= '0;
                r_rep[i] <= '0;
            end
            r_primed     <= '0;
            r_x          <= '0;
            r_idx        <= '0;
            r_acc_w      <= '0;
            r_rep_w      <= '0;
            r_primed_w   <= 1'b0;
            r_acc_n      <= '0;
            r_filt       <= '0;
            change_valid <= 1'b0;
            change_index <= '0;
            change_value <= '0;
            overrun      <= 1'b0;
            bad_index    <= 1'b0;
        end else begin
            change_valid <= 1'b0;
            if (value_valid && r_state != S_IDLE)
                overrun <= 1'b1;
            if (value_valid && r_state == S_IDLE && !w_in_range)
                bad_index <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x   <= value;
                        r_idx <= pot_index;
                    end
                end
                S_LOAD: begin
                    r_acc_w    <= r_acc[r_idx];
                    r_rep_w    <= r_rep[r_idx];
                    r_primed_w <= r_primed[r_idx];
                end
                S_FILTER: begin
                    r_acc_n <= w_acc_n;
                    r_filt  <= w_filt;
                end
                S_DECIDE: begin
                    r_acc[r_idx]    <= r_acc_n;
                    r_primed[r_idx] <= 1'b1;
                    if (w_upd) begin
                        r_rep[r_idx] <= r_filt;
                        change_valid <= 1'b1;
                        change_index <= r_idx;
                        change_value <= r_filt;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_POTS; g++) begin : g_out
        assign pot_values[10*g +: 10] = r_rep[g];
    end

endmodule

// File: tb/tb_pot_smoother.sv
// tb/tb_pot_smoother.sv - randomized and directed bench for pot_smoother against an arithmetic model
module tb_pot_smoother;

    localparam int NP = 12;
    localparam int SH = 2;
    localparam int HY = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [9:0]        value = '0;
    logic [3:0]        pot_index = '0;
    logic              value_valid = 1'b0;
    logic [10*NP-1:0]  pot_values;
    logic              change_valid;
    logic [3:0]        change_index;
    logic [9:0]        change_value;
    logic              overrun;
    logic              bad_index;

    pot_smoother #(.NUM_POTS(NP), .SHIFT(SH), .HYST(HY)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .value        (value),
        .pot_index    (pot_index),
        .value_valid  (value_valid),
        .pot_values   (pot_values),
        .change_valid (change_valid),
        .change_index (change_index),
        .change_value (change_value),
        .overrun      (overrun),
        .bad_index    (bad_index)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int m_acc [NP];
    int m_rep [NP];
    bit m_primed [NP];
    bit m_ovr;
    bit m_bad;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_acc[i] = 0;
            m_rep[i] = 0;
            m_primed[i] = 0;
        end
        m_ovr = 0;
        m_bad = 0;
    endtask

    function automatic logic [10*NP-1:0] model_vec();
        logic [10*NP-1:0] v;
        v = '0;
        for (int i = 0; i < NP; i++) v[10*i +: 10] = 10'(m_rep[i]);
        return v;
    endfunction

    // first-order low-pass a = 1/2^SH with rounding, then the reporting rules
    task automatic model_apply(input int idx, input int x, output bit upd, output int filt);
        int accn;
        int r;
        int d;
        r = m_rep[idx];
        if (!m_primed[idx]) begin
            accn = x * (1 << SH);
            filt = x;
        end else begin
            accn = m_acc[idx] - m_acc[idx] / (1 << SH) + x;
            filt = (accn + (1 << (SH - 1))) / (1 << SH);
            if (filt > 1023) filt = 1023;
        end
        d = filt - r;
        if (d < 0) d = -d;
        upd = !m_primed[idx] || d > HY || (filt == 0 && r != 0) || (filt == 1023 && r != 1023);
        m_acc[idx] = accn;
        m_primed[idx] = 1;
        if (upd) m_rep[idx] = filt;
    endtask

    // one sample; inj=1..3 drives a second sample onto edge E1..E3
    task automatic do_sample(input int idx, input int x, input int inj, input int iidx, input int ix);
        bit upd;
        int filt;
        upd = 0;
        filt = 0;
        @(negedge clk);
        value_valid = 1'b1;
        value = 10'(x);
        pot_index = 4'(idx);
        @(negedge clk);
        value_valid = 1'b0;
        if (idx < NP) model_apply(idx, x, upd, filt);
        else m_bad = 1;
        if (inj == 1) begin
            value_valid = 1'b1; value = 10'(ix); pot_index = 4'(iidx);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            value_valid = 1'b0;
            if (inj == c + 1) begin
                value_valid = 1'b1; value = 10'(ix); pot_index = 4'(iidx);
            end
            if (c < 3) check("cv_early", change_valid, 0);
            else begin
                check("cv", change_valid, upd);
                if (upd) begin
                    check("cidx", change_index, idx);
                    check("cval", change_value, filt);
                end
            end
        end
        if (inj != 0) m_ovr = 1;
        check("pot_values", pot_values, model_vec());
        check("overrun", overrun, m_ovr);
        check("bad_index", bad_index, m_bad);
    endtask

    initial begin
        int idx;
        int x;
        int inj;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_pv", pot_values, 0);
        check("rst_cv", change_valid, 0);
        check("rst_flags", {overrun, bad_index, change_index, change_value}, 0);
        rst_n = 1'b1;

        do_sample(3, 500, 0, 0, 0);
        check("first_500", pot_values[39:30], 500);
        do_sample(3, 504, 0, 0, 0);
        check("hyst_hold", pot_values[39:30], 500);

        do_sample(0, 0, 0, 0, 0);
        do_sample(0, 1023, 0, 0, 0);
        check("ramp1", pot_values[9:0], 256);
        do_sample(0, 1023, 0, 0, 0);
        check("ramp2", pot_values[9:0], 448);
        for (int k = 0; k < 38; k++) do_sample(0, 1023, 0, 0, 0);
        check("ramp_end", pot_values[9:0], 1023);

        do_sample(1, 100, 2, 2, 200);
        check("ovr_set", overrun, 1);
        check("ovr_ch2", pot_values[29:20], 0);
        do_sample(2, 200, 0, 0, 0);
        check("after_ovr", pot_values[29:20], 200);

        do_sample(12, 77, 0, 0, 0);
        do_sample(15, 88, 0, 0, 0);
        check("bad_set", bad_index, 1);
        do_sample(4, 321, 0, 0, 0);

        // reset while idx 5 is in FILTER
        @(negedge clk);
        value_valid = 1'b1; value = 10'd300; pot_index = 4'd5;
        @(negedge clk);
        value_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_pv", pot_values, 0);
        check("mid_rst_misc", {change_valid, overrun, bad_index, change_index, change_value}, 0);
        @(negedge clk);
        check("mid_rst_cv", change_valid, 0);
        rst_n = 1'b1;
        do_sample(5, 300, 0, 0, 0);
        check("rst_unprimed", pot_values[59:50], 300);

        for (int n = 0; n < 200; n++) begin
            idx = $urandom_range(0, NP - 1);
            if ($urandom_range(0, 19) == 0) idx = $urandom_range(NP, 15);
            if ($urandom_range(0, 1) == 0 && idx < NP) begin
                x = m_rep[idx] + $urandom_range(0, 10) - 5;
                if (x < 0) x = 0;
                if (x > 1023) x = 1023;
            end else begin
                x = $urandom_range(0, 1023);
            end
            inj = ($urandom_range(0, 9) == 0 && idx < NP) ? $urandom_range(1, 3) : 0;
            do_sample(idx, x, inj, $urandom_range(0, NP - 1), $urandom_range(0, 1023));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pot_smoother.md
Name: pot_smoother

Overview:
- Sits directly downstream of the ADC pot controller.
- Consumes its per-pot sample stream (value, pot_index, value_valid), applies a per-channel first-order IIR low-pass and a hysteresis gate, and holds a stable 10-bit reading for every pot.
- Emits a one-cycle change strobe whenever a reported reading moves. The synth/effects parameter logic consumes these outputs directly.

Parameters:
- NUM_POTS, 12, number of channels; valid indices are 0..NUM_POTS-1.
- SHIFT, 2, IIR smoothing shift (alpha = 2^-SHIFT); legal range 1..6.
- HYST, 2, minimum absolute difference, exclusive, required to update a reported value.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- value  in  10  ADC sample.
- pot_index  in  4  channel of the sample.
- value_valid  in  1  one-cycle sample strobe.
- pot_values  out  10*NUM_POTS  flat array of reported values; channel i occupies bits [10i+9:10i].
- change_valid  out  1  one-cycle pulse when a reported value is updated.
- change_index  out  4  channel that changed.
- change_value  out  10  new reported value.
- overrun  out  1  sticky; a sample arrived while busy.
- bad_index  out  1  sticky; a sample arrived with pot_index >= NUM_POTS.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately):
  - pot_values, change_valid, change_index, change_value, overrun, bad_index all 0.
  - All accumulators 0; all per-channel primed bits cleared; FSM to IDLE.
  - Applies even mid-operation; any in-flight sample is discarded.
- Per-channel state:
  - acc[i], width 10+SHIFT.
  - rep[i], 10 bits (drives pot_values).
  - primed[i], 1 bit.
- FSM: IDLE -> LOAD -> FILTER -> DECIDE -> IDLE, one clock per state.
  - IDLE: on an edge E0 with value_valid=1:
    - If pot_index < NUM_POTS, latch value and index, go to LOAD.
    - Otherwise set bad_index and stay in IDLE.
  - LOAD (E1): read acc[idx], rep[idx], primed[idx] into working registers.
  - FILTER (E2):
    - If not primed: acc_n = x << SHIFT, filt = x.
    - Else: acc_n = acc - (acc >> SHIFT) + x; filt = min((acc_n + 2^(SHIFT-1)) >> SHIFT, 1023).
    - Widths: acc_n never exceeds 1023 << SHIFT; no overflow permitted.
  - DECIDE (E3): write acc[idx] = acc_n and primed[idx] = 1. Update when any of these holds:
    - channel was not primed;
    - |filt - rep| > HYST;
    - filt == 0 and rep != 0;
    - filt == 1023 and rep != 1023.
  - On update, registered at E3:
    - rep[idx] = filt.
    - change_valid = 1 for exactly one cycle.
    - change_index = idx, change_value = filt.
  - If there is no update, change_valid stays 0; change_index and change_value hold their previous values.
- Latency: sample accepted at E0 -> change_valid and pot_values visible after E3 (3 cycles).
- Acceptance: a new sample is accepted at E4 at the earliest.
- Overrun: value_valid=1 at E1, E2 or E3 -> sample dropped, overrun set. No state corruption.
- overrun and bad_index clear only on reset.
- pot_values change only in DECIDE, and only for the addressed channel.

Test Plan:
- Defaults SHIFT=2, HYST=2. Reset, then sample idx 3 = 500 -> change_valid pulse 3 cycles after acceptance with index 3, value 500; pot_values[39:30] = 500; all other fields 0.
- After the previous scenario, idx 3 = 504 -> acc 2004, filt 501, diff 1 -> no change_valid; pot_values[3] stays 500.
- Prime idx 0 = 0, then feed 1023 repeatedly:
  - Successive filt values 256, 448, 592, 700, ...
  - A change strobe fires each time diff > 2.
  - The endpoint rule forces a final report of exactly 1023.
  - No value ever exceeds 1023.
- value_valid at E0 (idx 1 = 100) and again at E2 (idx 2 = 200) -> only idx 1 processed; overrun = 1; pot_values[2] stays 0; a later idx 2 sample at E4 is accepted normally.
- Sample with pot_index 12 or 15 -> no FSM activity, no change_valid, bad_index = 1; a following valid sample processes normally.
- Assert rst_n low during FILTER of idx 5 = 300 -> all outputs 0 immediately, no change_valid; after release, idx 5 = 300 is treated as unprimed and reports 300.
